// File: rtl/memwb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memwb_stage
//  Description : MEM/WB pipeline register. Captures each instruction leaving
//                the MEM stage, selects the writeback data and resolves
//                per-flag partial updates into a full flag word, so the
//                condition code register can load MEMWB_flags whenever
//                MEMWB_valid is high. Supports RTI flag restore from memory
//                read data, plus stall and flush bubbles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: MEMWB_PERF_EN
//      Adds perf_clear input and 16-bit saturating perf_retired /
//      perf_bubbles counters. Core behaviour is identical in both builds.
// ----------------------------------------------------------------------------
//  Ports:
//      clk                 in   rising-edge clock
//      reset               in   synchronous active-high reset
//      stall / flush       in   insert a bubble into MEM/WB
//      EXMEM_valid         in   MEM-stage instruction is real
//      EXMEM_alu_result    in   ALU result            [DATA_W]
//      EXMEM_mem_to_reg    in   writeback from memory data
//      EXMEM_reg_write     in   instruction writes the register file
//      EXMEM_rd            in   destination register  [REG_AW]
//      EXMEM_flags         in   flags from EX         [FLAG_W], {V,C,N,Z}
//      EXMEM_flag_mask     in   per-bit flag update enable
//      EXMEM_flag_restore  in   RTI: flags from mem_rdata[FLAG_W-1:0]
//      mem_rdata           in   data memory read data [DATA_W]
//      perf_clear          in   (MEMWB_PERF_EN) zero both counters
//      perf_retired        out  (MEMWB_PERF_EN) loads counted
//      perf_bubbles        out  (MEMWB_PERF_EN) non-load cycles counted
//      MEMWB_valid         out  writeback instruction is real
//      MEMWB_reg_write     out  register-file write enable, gated by valid
//      MEMWB_rd            out  destination register
//      MEMWB_wdata         out  writeback data
//      MEMWB_flags         out  full flag word for the condition code reg
// ============================================================================
module memwb_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              EXMEM_valid,
    input  logic [DATA_W-1:0] EXMEM_alu_result,
    input  logic              EXMEM_mem_to_reg,
    input  logic              EXMEM_reg_write,
    input  logic [REG_AW-1:0] EXMEM_rd,
    input  logic [FLAG_W-1:0] EXMEM_flags,
    input  logic [FLAG_W-1:0] EXMEM_flag_mask,
    input  logic              EXMEM_flag_restore,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEMWB_PERF_EN
    input  logic              perf_clear,
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_bubbles,
`endif
    output logic              MEMWB_valid,
    output logic              MEMWB_reg_write,
    output logic [REG_AW-1:0] MEMWB_rd,
    output logic [DATA_W-1:0] MEMWB_wdata,
    output logic [FLAG_W-1:0] MEMWB_flags
);

    logic              r_valid_q,     w_valid_d;
    logic              r_reg_write_q, w_reg_write_d;
    logic [REG_AW-1:0] r_rd_q,        w_rd_d;
    logic [DATA_W-1:0] r_wdata_q,     w_wdata_d;
    logic [FLAG_W-1:0] r_flags_q,     w_flags_d;

    logic              w_load;
    logic [FLAG_W-1:0] w_flag_track;
    logic [FLAG_W-1:0] w_flags_new;

    // The tracked "committed" flag value loads and holds under exactly the
    // same conditions as the MEMWB flag register and shares its reset value,
    // so the two are always equal; one register serves both roles.
    assign w_flag_track = r_flags_q;

    always_comb begin
        w_load = EXMEM_valid & ~stall & ~flush;

        // RTI pops the whole flag word; otherwise only masked bits change
        // and the rest keep the value the CCR will hold after the previous
        // instruction commits.
        if (EXMEM_flag_restore) begin
            w_flags_new = mem_rdata[FLAG_W-1:0];
        end else begin
            w_flags_new = (EXMEM_flag_mask & EXMEM_flags) |
                          (~EXMEM_flag_mask & w_flag_track);
        end

        // Bubbles clear valid/write-enable but hold the payload so that
        // MEMWB_flags keeps reflecting the committed value.
        w_valid_d     = 1'b0;
        w_reg_write_d = 1'b0;
        w_rd_d        = r_rd_q;
        w_wdata_d     = r_wdata_q;
        w_flags_d     = r_flags_q;
        if (w_load) begin
            w_valid_d     = 1'b1;
            w_reg_write_d = EXMEM_reg_write;
            w_rd_d        = EXMEM_rd;
            w_wdata_d     = EXMEM_mem_to_reg ? mem_rdata : EXMEM_alu_result;
            w_flags_d     = w_flags_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q     <= 1'b0;
            r_reg_write_q <= 1'b0;
            r_rd_q        <= '0;
            r_wdata_q     <= '0;
            r_flags_q     <= '0;
        end else begin
            r_valid_q     <= w_valid_d;
            r_reg_write_q <= w_reg_write_d;
            r_rd_q        <= w_rd_d;
            r_wdata_q     <= w_wdata_d;
            r_flags_q     <= w_flags_d;
        end
    end

    assign MEMWB_valid     = r_valid_q;
    assign MEMWB_reg_write = r_reg_write_q;
    assign MEMWB_rd        = r_rd_q;
    assign MEMWB_wdata     = r_wdata_q;
    assign MEMWB_flags     = r_flags_q;

`ifdef MEMWB_PERF_EN
    logic [15:0] r_retired_q, w_retired_d;
    logic [15:0] r_bubbles_q, w_bubbles_d;

    always_comb begin
        w_retired_d = r_retired_q;
        w_bubbles_d = r_bubbles_q;
        if (perf_clear) begin
            w_retired_d = '0;
            w_bubbles_d = '0;
        end else if (w_load) begin
            if (r_retired_q != 16'hFFFF) w_retired_d = r_retired_q + 16'd1;
        end else begin
            if (r_bubbles_q != 16'hFFFF) w_bubbles_d = r_bubbles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_q <= '0;
            r_bubbles_q <= '0;
        end else begin
            r_retired_q <= w_retired_d;
            r_bubbles_q <= w_bubbles_d;
        end
    end

    assign perf_retired = r_retired_q;
    assign perf_bubbles = r_bubbles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memwb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memwb_stage
//  Description : Self-checking bench for memwb_stage. A behavioural model of
//                the condition code register and writeback slot is checked
//                against the DUT every cycle; directed steps pin the model
//                with hand-computed values, then randomized traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memwb_stage;

    logic       clk = 1'b0;
    logic       reset, stall, flush;
    logic       ex_valid, ex_m2r, ex_rw, ex_restore;
    logic [7:0] ex_alu, mem_rdata;
    logic [1:0] ex_rd;
    logic [3:0] ex_flags, ex_mask;

    logic       wb_valid, wb_rw;
    logic [1:0] wb_rd;
    logic [7:0] wb_wdata;
    logic [3:0] wb_flags;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    memwb_stage #(.DATA_W(8), .REG_AW(2), .FLAG_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .flush              (flush),
        .EXMEM_valid        (ex_valid),
        .EXMEM_alu_result   (ex_alu),
        .EXMEM_mem_to_reg   (ex_m2r),
        .EXMEM_reg_write    (ex_rw),
        .EXMEM_rd           (ex_rd),
        .EXMEM_flags        (ex_flags),
        .EXMEM_flag_mask    (ex_mask),
        .EXMEM_flag_restore (ex_restore),
        .mem_rdata          (mem_rdata),
        .MEMWB_valid        (wb_valid),
        .MEMWB_reg_write    (wb_rw),
        .MEMWB_rd           (wb_rd),
        .MEMWB_wdata        (wb_wdata),
        .MEMWB_flags        (wb_flags)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ccr: what the condition code register holds once everything loaded so
    // far has committed. Each flag bit is updated individually.
    logic       m_valid, m_rw;
    logic [1:0] m_rd;
    logic [7:0] m_wdata;
    logic [3:0] ccr;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 0; m_rw = 0; m_rd = 0; m_wdata = 0; ccr = 0;
        end else if (ex_valid && !stall && !flush) begin
            m_valid = 1;
            m_rw    = ex_rw;
            m_rd    = ex_rd;
            m_wdata = ex_m2r ? mem_rdata : ex_alu;
            for (int b = 0; b < 4; b++) begin
                if (ex_restore)      ccr[b] = mem_rdata[b];
                else if (ex_mask[b]) ccr[b] = ex_flags[b];
            end
        end else begin
            m_valid = 0;
            m_rw    = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",     {31'd0, wb_valid}, {31'd0, m_valid});
            check("reg_write", {31'd0, wb_rw},    {31'd0, m_rw});
            check("rd",        {30'd0, wb_rd},    {30'd0, m_rd});
            check("wdata",     {24'd0, wb_wdata}, {24'd0, m_wdata});
            check("flags",     {28'd0, wb_flags}, {28'd0, ccr});
        end
    end

    // Apply one cycle of inputs; returns on the following negedge, after the
    // edge that consumed them.
    task automatic cyc(input logic rs, input logic v, input logic st,
                       input logic fl, input logic [7:0] alu,
                       input logic [1:0] rd, input logic rw, input logic m2r,
                       input logic [3:0] flg, input logic [3:0] msk,
                       input logic rest, input logic [7:0] rdata);
        reset = rs; ex_valid = v; stall = st; flush = fl; ex_alu = alu;
        ex_rd = rd; ex_rw = rw; ex_m2r = m2r; ex_flags = flg; ex_mask = msk;
        ex_restore = rest; mem_rdata = rdata;
        @(negedge clk);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 4'h0, 0, 8'h00);
        chk_en = 1'b1;

        // Idle after reset: everything zero for 5 cycles.
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 0, 8'hFF, 3, 1, 0, 4'hF, 4'hF, 0, 8'hFF);
        check("idle_valid", {31'd0, wb_valid}, 32'd0);
        check("idle_flags", {28'd0, wb_flags}, 32'd0);
        check("idle_wdata", {24'd0, wb_wdata}, 32'd0);

        // Full-mask load.
        cyc(0, 1, 0, 0, 8'h3C, 2, 1, 0, 4'b0101, 4'hF, 0, 8'h77);
        check("load_valid", {31'd0, wb_valid}, 32'd1);
        check("load_wdata", {24'd0, wb_wdata}, 32'h3C);
        check("load_rd",    {30'd0, wb_rd},    32'd2);
        check("load_flags", {28'd0, wb_flags}, 32'b0101);

        // Back-to-back partial update, then a flag-neutral instruction.
        cyc(0, 1, 0, 0, 8'h11, 1, 1, 0, 4'b1010, 4'b0011, 0, 8'h00);
        check("partial_flags", {28'd0, wb_flags}, 32'b0110);
        cyc(0, 1, 0, 0, 8'h22, 3, 0, 0, 4'b1001, 4'b0000, 0, 8'h00);
        check("mask0_flags", {28'd0, wb_flags}, 32'b0110);

        // RTI restore from popped memory data.
        cyc(0, 1, 0, 0, 8'h55, 0, 1, 1, 4'b0000, 4'h0, 1, 8'hA9);
        check("rti_flags", {28'd0, wb_flags}, 32'b1001);
        check("rti_wdata", {24'd0, wb_wdata}, 32'hA9);

        // Two stall cycles then a flush: three bubbles, flags held.
        cyc(0, 1, 1, 0, 8'h66, 1, 1, 0, 4'hF, 4'hF, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h66, 1, 1, 0, 4'hF, 4'hF, 0, 8'h00);
        cyc(0, 1, 0, 1, 8'h66, 1, 1, 0, 4'hF, 4'hF, 0, 8'h00);
        check("bubble_valid", {31'd0, wb_valid}, 32'd0);
        check("bubble_rw",    {31'd0, wb_rw},    32'd0);
        check("bubble_flags", {28'd0, wb_flags}, 32'b1001);
        cyc(0, 1, 0, 0, 8'h77, 2, 1, 0, 4'b0110, 4'b0100, 0, 8'h00);
        check("post_bubble_flags", {28'd0, wb_flags}, 32'b1101);

        // Reset with an instruction in flight.
        cyc(0, 1, 0, 0, 8'h88, 3, 1, 0, 4'hF, 4'hF, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h99, 3, 1, 0, 4'hF, 4'hF, 0, 8'h00);
        check("rst_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_flags", {28'd0, wb_flags}, 32'd0);
        check("rst_wdata", {24'd0, wb_wdata}, 32'd0);
        cyc(0, 1, 0, 0, 8'h01, 1, 1, 0, 4'hF, 4'b0001, 0, 8'h00);
        check("post_rst_flags", {28'd0, wb_flags}, 32'b0001);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) < 2), ($urandom_range(99) < 75),
                ($urandom_range(99) < 20), ($urandom_range(99) < 10),
                8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom), 4'($urandom), ($urandom_range(99) < 15),
                8'($urandom));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
